// File: rtl/instruction_loader_pkg.sv
// Shared MIPS definitions: instruction memory depth and the loader's state encoding.
package instruction_loader_pkg;

    localparam int unsigned IMEM_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        DONE,
        ERROR
    } loader_state_t;

    // A header count is unusable when it names more words than the memory holds.
    function automatic logic count_exceeds(input logic [15:0] count, input int unsigned depth);
        return 32'(count) > depth;
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream, instruction-memory write and core-control signals of the loader.
interface instruction_loader_if;

    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );

endinterface

// File: rtl/instruction_loader_byte_packer.sv
// Big-endian 4-byte shift register; flags the shift that completes a word.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        complete
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    // The word including the byte being shifted in now, so a write can be issued on the same edge.
    assign word     = {word_q[23:0], data};
    assign complete = shift && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift) begin
            word_q <= word;
            cnt_q  <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: streams a framed program image into instruction memory while holding the core.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH
) (
    input logic                 clk,
    input logic                 reset,
    instruction_loader_if.slave bus
);

    loader_state_t state_q, state_d;

    logic [7:0]  n_hi_q;
    logic [15:0] n_q;
    logic [16:0] word_cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accepting;
    logic        xfer;
    logic [15:0] header;
    logic        pk_clear;
    logic        pk_shift;
    logic [31:0] pk_word;
    logic        pk_complete;
    logic        last_word;

    assign accepting = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
    assign xfer      = bus.in_valid && accepting;
    assign header    = {n_hi_q, bus.in_data};
    assign pk_clear  = xfer && (state_q == HDR_LO);
    assign pk_shift  = xfer && (state_q == DATA);
    assign last_word = (word_cnt_q + 17'd1) == {1'b0, n_q};

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (pk_clear),
        .shift    (pk_shift),
        .data     (bus.in_data),
        .word     (pk_word),
        .complete (pk_complete)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready = accepting;
        bus.cpu_hold = 1'b0;
        bus.done     = 1'b0;
        bus.error    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = HDR_HI;
            end
            HDR_HI: begin
                bus.cpu_hold = 1'b1;
                if (xfer) state_d = HDR_LO;
            end
            HDR_LO: begin
                bus.cpu_hold = 1'b1;
                if (xfer) begin
                    if (header == '0)                      state_d = DONE;
                    else if (count_exceeds(header, DEPTH)) state_d = ERROR;
                    else                                   state_d = DATA;
                end
            end
            DATA: begin
                bus.cpu_hold = 1'b1;
                // Leave on the edge that issues the final write so release and write land together.
                if (pk_complete && last_word) state_d = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                if (bus.start) state_d = HDR_HI;
            end
            ERROR: begin
                bus.cpu_hold = 1'b1;
                bus.error    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_hi_q     <= '0;
            n_q        <= '0;
            word_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            we_q <= 1'b0;
            if (xfer && (state_q == HDR_HI)) n_hi_q <= bus.in_data;
            if (pk_clear) begin
                n_q        <= header;
                word_cnt_q <= '0;
            end
            if (pk_complete) begin
                we_q       <= 1'b1;
                addr_q     <= 32'(word_cnt_q);
                wdata_q    <= pk_word;
                word_cnt_q <= word_cnt_q + 17'd1;
            end
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader against a word-image memory model.
module tb_instruction_loader;
    import instruction_loader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_loader_if bus ();

    instruction_loader #(.DEPTH(IMEM_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int writes = 0;
    logic [31:0] mem [0:IMEM_DEPTH-1];

    // Instruction memory model: synchronous write port, counts every strobe.
    always @(posedge clk) begin
        if (bus.imem_we) begin
            writes <= writes + 1;
            if (bus.imem_addr < IMEM_DEPTH) mem[bus.imem_addr[7:0]] <= bus.imem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            bus.in_data = 8'($urandom);
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            if (acc) break;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL byte_accept: byte %h not accepted within 50 cycles", b);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic load_frame(input logic [15:0] n, input logic [31:0] w[$], input int unsigned maxgap);
        logic [31:0] x;
        send_byte(n[15:8], $urandom_range(maxgap, 0));
        send_byte(n[7:0], $urandom_range(maxgap, 0));
        foreach (w[i]) begin
            x = w[i];
            for (int k = 3; k >= 0; k--) send_byte(x[k*8 +: 8], $urandom_range(maxgap, 0));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.imem_we, bus.cpu_hold, bus.done, bus.error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.in_ready, bus.imem_we, bus.cpu_hold, bus.done, bus.error});
        end
        checks++;
        if ({bus.imem_addr, bus.imem_wdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_bus: got addr %h wdata %h expected 0", bus.imem_addr, bus.imem_wdata);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected IDLE", dut.state_q);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_load();
        logic [31:0] w[$];
        int w0;
        w  = '{32'h2008_0005, 32'hAC08_0004};
        w0 = writes;
        pulse_start();
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.cpu_hold, bus.done} !== 3'b110) begin
            errors++;
            $display("FAIL basic_header_state: got %b expected 110", {bus.in_ready, bus.cpu_hold, bus.done});
        end
        tick();
        load_frame(16'd2, w, 0);
        @(negedge clk);
        checks++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 32'd1, 32'hAC08_0004}) begin
            errors++;
            $display("FAIL basic_last_write: got we %b addr %h wdata %h expected 1 1 ac080004",
                     bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        checks++;
        if ({bus.done, bus.cpu_hold, bus.in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL basic_release: got done/hold/ready %b expected 100",
                     {bus.done, bus.cpu_hold, bus.in_ready});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({mem[0], mem[1]} !== {w[0], w[1]} || writes - w0 != 2 || bus.imem_we !== 1'b0) begin
            errors++;
            $display("FAIL basic_image: got %h %h writes %0d we %b expected %h %h writes 2 we 0",
                     mem[0], mem[1], writes - w0, bus.imem_we, w[0], w[1]);
        end
    endtask

    task automatic test_zero_header();
        logic [31:0] w[$];
        int w0;
        w0 = writes;
        pulse_start();
        load_frame(16'd0, w, 0);
        @(negedge clk);
        checks++;
        if ({bus.done, bus.cpu_hold} !== 2'b10) begin
            errors++;
            $display("FAIL zero_done: got done/hold %b expected 10", {bus.done, bus.cpu_hold});
        end
        repeat (3) tick();
        checks++;
        if (writes != w0) begin
            errors++;
            $display("FAIL zero_no_write: got %0d writes expected 0", writes - w0);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] w[$];
        int w0;
        int bad;
        bad = 0;
        for (int i = 0; i < 8; i++) w.push_back($urandom);
        w0 = writes;
        pulse_start();
        load_frame(16'd8, w, 3);
        @(negedge clk);
        checks++;
        if ({bus.done, bus.cpu_hold} !== 2'b10) begin
            errors++;
            $display("FAIL gaps_done: got done/hold %b expected 10", {bus.done, bus.cpu_hold});
        end
        tick();
        checks++;
        if (writes - w0 != 8) begin
            errors++;
            $display("FAIL gaps_write_count: got %0d expected 8", writes - w0);
        end
        foreach (w[i]) if (mem[i] !== w[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gaps_image: got %0d mismatching words expected 0", bad);
        end
    endtask

    task automatic test_reload();
        logic [31:0] w[$];
        int w0;
        w  = '{32'hDEAD_BEEF};
        w0 = writes;
        pulse_start();
        load_frame(16'd1, w, 1);
        tick();
        @(negedge clk);
        checks++;
        if (mem[0] !== 32'hDEAD_BEEF || writes - w0 != 1 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL reload: got mem0 %h writes %0d done %b expected deadbeef 1 1",
                     mem[0], writes - w0, bus.done);
        end
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.cpu_hold, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_beats_start: got ready/hold/done %b expected 000",
                     {bus.in_ready, bus.cpu_hold, bus.done});
        end
    endtask

    task automatic test_depth_boundary();
        logic [31:0] w[$];
        pulse_start();
        load_frame(16'd256, w, 0);
        @(negedge clk);
        checks++;
        if ({bus.error, bus.in_ready, bus.cpu_hold} !== 3'b011) begin
            errors++;
            $display("FAIL depth_boundary: got err/ready/hold %b expected 011",
                     {bus.error, bus.in_ready, bus.cpu_hold});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w[$];
        int w0;
        for (int i = 0; i < 2; i++) w.push_back($urandom);
        w0 = writes;
        pulse_start();
        load_frame(16'd4, w, 1);
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.imem_we, bus.cpu_hold, bus.in_ready, bus.done} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_idle: got we/hold/ready/done %b expected 0000",
                     {bus.imem_we, bus.cpu_hold, bus.in_ready, bus.done});
        end
        bus.in_valid = 1'b1;
        repeat (8) begin
            bus.in_data = 8'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (writes - w0 != 2 || mem[0] !== w[0] || mem[1] !== w[1]) begin
            errors++;
            $display("FAIL mid_reset_retain: got writes %0d mem %h %h expected 2 %h %h",
                     writes - w0, mem[0], mem[1], w[0], w[1]);
        end
    endtask

    task automatic test_error();
        logic [31:0] w[$];
        int w0;
        w0 = writes;
        pulse_start();
        load_frame(16'd257, w, 0);
        @(negedge clk);
        checks++;
        if ({bus.error, bus.cpu_hold, bus.in_ready, bus.done} !== 4'b1100) begin
            errors++;
            $display("FAIL error_flags: got err/hold/ready/done %b expected 1100",
                     {bus.error, bus.cpu_hold, bus.in_ready, bus.done});
        end
        bus.in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_data = 8'($urandom);
            bus.start   = (i == 4);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        @(negedge clk);
        checks++;
        if (writes != w0 || bus.error !== 1'b1) begin
            errors++;
            $display("FAIL error_absorbing: got writes %0d error %b expected 0 1", writes - w0, bus.error);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.error, bus.cpu_hold} !== 2'b00) begin
            errors++;
            $display("FAIL error_cleared: got err/hold %b expected 00", {bus.error, bus.cpu_hold});
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        reset        = 1'b1;
        test_reset();
        test_basic_load();
        test_zero_header();
        test_gaps();
        test_reload();
        test_depth_boundary();
        test_reset_mid_load();
        test_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
